// File: rtl/axi_sort_unpacker.sv
// rtl/axi_sort_unpacker.sv - splits packed 2x16-bit beats into an element stream
// and gathers per-frame duplicate/element counts and a sticky sort-order error flag.
module axi_sort_unpacker #(
  parameter int DATA_WIDTH = 32,
  parameter int ELEM_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sort_dir,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  output logic [ELEM_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [CNT_WIDTH-1:0]  dup_nums,
  output logic [CNT_WIDTH-1:0]  elem_cnt,
  output logic                  order_err,
  output logic                  done
);

  typedef enum logic [1:0] {EMPTY, LO, HI} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
  logic                  buf_last_q, buf_last_d;
  logic                  first_q, first_d;
  logic                  dir_q, dir_d;
  logic [ELEM_WIDTH-1:0] prev_q, prev_d;
  logic [CNT_WIDTH-1:0]  dup_q, dup_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  dup_nums_q, dup_nums_d;
  logic [CNT_WIDTH-1:0]  elem_cnt_q, elem_cnt_d;
  logic                  order_err_q, order_err_d;
  logic                  done_q, done_d;
  logic                  m_hs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      buf_data_q <= '0;
      buf_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_data_q <= buf_data_d;
      buf_last_q <= buf_last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    buf_data_d = buf_data_q;
    buf_last_d = buf_last_q;
    case (state_q)
      EMPTY: begin
        if (s_tvalid) begin
          buf_data_d = s_tdata;
          buf_last_d = s_tlast;
          state_d    = LO;
        end
      end
      LO: begin
        if (m_tready) state_d = HI;
      end
      HI: begin
        if (m_tready) begin
          if (s_tvalid) begin
            buf_data_d = s_tdata;
            buf_last_d = s_tlast;
            state_d    = LO;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Gating with reset keeps s_tready low for the whole reset assertion.
  always_comb begin
    s_tready = 1'b0;
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    case (state_q)
      EMPTY: s_tready = !reset;
      LO: begin
        m_tvalid = 1'b1;
        m_tdata  = buf_data_q[ELEM_WIDTH-1:0];
      end
      HI: begin
        m_tvalid = 1'b1;
        m_tdata  = buf_data_q[DATA_WIDTH-1:ELEM_WIDTH];
        m_tlast  = buf_last_q;
        s_tready = m_tready;
      end
      default: ;
    endcase
  end

  assign m_hs = m_tvalid && m_tready;

  always_comb begin
    first_d     = first_q;
    dir_d       = dir_q;
    prev_d      = prev_q;
    dup_d       = dup_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    dup_nums_d  = dup_nums_q;
    elem_cnt_d  = elem_cnt_q;
    order_err_d = order_err_q;
    done_d      = 1'b0;
    if (m_hs) begin
      prev_d = m_tdata;
      if (first_q) begin
        dir_d = sort_dir;
        cnt_d = CNT_ONE;
        dup_d = '0;
        err_d = 1'b0;
      end else begin
        if (m_tdata == prev_q) begin
          dup_d = (dup_q == CNT_MAX) ? dup_q : dup_q + CNT_ONE;
        end else if ((dir_q && (m_tdata < prev_q)) || (!dir_q && (m_tdata > prev_q))) begin
          err_d = 1'b1;
        end
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      end
      // Re-arm first so a new frame never compares against the old tail.
      first_d = m_tlast;
      if (m_tlast) begin
        dup_nums_d  = dup_d;
        elem_cnt_d  = cnt_d;
        order_err_d = err_d;
        done_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_q     <= 1'b1;
      dir_q       <= 1'b0;
      prev_q      <= '0;
      dup_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      dup_nums_q  <= '0;
      elem_cnt_q  <= '0;
      order_err_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      first_q     <= first_d;
      dir_q       <= dir_d;
      prev_q      <= prev_d;
      dup_q       <= dup_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      dup_nums_q  <= dup_nums_d;
      elem_cnt_q  <= elem_cnt_d;
      order_err_q <= order_err_d;
      done_q      <= done_d;
    end
  end

  assign dup_nums  = dup_nums_q;
  assign elem_cnt  = elem_cnt_q;
  assign order_err = order_err_q;
  assign done      = done_q;

endmodule

// File: tb/tb_axi_sort_unpacker.sv
// tb/tb_axi_sort_unpacker.sv - directed and randomized frames checked against a
// queue-based element/statistics model.
module tb_axi_sort_unpacker;

  logic        clk = 1'b0;
  logic        reset;
  logic        sort_dir;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [15:0] dup_nums;
  logic [15:0] elem_cnt;
  logic        order_err;
  logic        done;

  axi_sort_unpacker #(.DATA_WIDTH(32), .ELEM_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .sort_dir(sort_dir),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .dup_nums(dup_nums), .elem_cnt(elem_cnt), .order_err(order_err), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {logic [15:0] d; logic last; logic lo;} elem_t;
  typedef struct {int dup; int cnt; logic err;} stat_t;

  elem_t       exp_q[$];
  stat_t       stat_q[$];
  logic [15:0] frame[$];
  int          hs_cyc[$];
  logic        fdir;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          mode = 0;
  logic        rand_dir = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // m_tready pattern: 0 always ready, 1 alternating, 2 random, 3 left to main
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: m_tready = 1'b1;
        1: m_tready = !m_tready;
        2: m_tready = 1'($urandom_range(0, 1));
        default: ;
      endcase
      if (rand_dir) sort_dir = 1'($urandom_range(0, 1));
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_beat(input logic [31:0] d, input logic l);
    int n;
    elem_t e;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (s_tready) begin
        e.d = d[15:0];  e.last = 1'b0; e.lo = 1'b1; exp_q.push_back(e);
        e.d = d[31:16]; e.last = l;    e.lo = 1'b0; exp_q.push_back(e);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      n++;
    end
    flag("beat_accept_timeout");
    s_tvalid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (done) return;
      n++;
    end
    flag("done_timeout");
  endtask

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  // Compare process: element order, stall stability, s_tready in low half, frame stats.
  initial begin
    logic        prev_stall;
    logic [15:0] prev_d;
    logic        prev_l;
    elem_t       ex;
    stat_t       st;
    prev_stall = 1'b0;
    prev_d = '0;
    prev_l = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        stat_q.delete();
        frame.delete();
        prev_stall = 1'b0;
      end else begin
        if (done) begin
          if (stat_q.size() == 0) flag("done_unexpected");
          else begin
            st = stat_q.pop_front();
            chk("dup_nums", 32'(dup_nums), 32'(st.dup));
            chk("elem_cnt", 32'(elem_cnt), 32'(st.cnt));
            chk("order_err", 32'(order_err), 32'(st.err));
            done_cnt++;
          end
        end
        if (prev_stall) begin
          chk("stall_valid", 32'(m_tvalid), 32'd1);
          chk("stall_data", 32'(m_tdata), 32'(prev_d));
          chk("stall_last", 32'(m_tlast), 32'(prev_l));
        end
        if (m_tvalid) begin
          if (exp_q.size() == 0) flag("element_unexpected");
          else begin
            ex = exp_q[0];
            if (ex.lo) chk("s_tready_in_lo", 32'(s_tready), 32'd0);
            if (m_tready) begin
              void'(exp_q.pop_front());
              chk("m_tdata", 32'(m_tdata), 32'(ex.d));
              chk("m_tlast", 32'(m_tlast), 32'(ex.last));
              hs_cyc.push_back(cyc);
              if (frame.size() == 0) fdir = sort_dir;
              frame.push_back(ex.d);
              if (ex.last) begin
                st.dup = 0;
                st.err = 1'b0;
                st.cnt = frame.size();
                for (int i = 1; i < frame.size(); i++) begin
                  if (frame[i] == frame[i-1]) st.dup++;
                  else if (fdir ? (frame[i] < frame[i-1]) : (frame[i] > frame[i-1])) st.err = 1'b1;
                end
                stat_q.push_back(st);
                frame.delete();
              end
            end
          end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_d = m_tdata;
        prev_l = m_tlast;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int n;
    logic [15:0] v;
    logic [15:0] lo_v;
    int nb;
    logic asc;
    reset = 1'b1;
    s_tvalid = 1'b0;
    s_tdata = '0;
    s_tlast = 1'b0;
    sort_dir = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tdata", 32'(m_tdata), 32'd0);
    chk("rst_m_tlast", 32'(m_tlast), 32'd0);
    chk("rst_dup", 32'(dup_nums), 32'd0);
    chk("rst_cnt", 32'(elem_cnt), 32'd0);
    chk("rst_err", 32'(order_err), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    realign();
    chk("post_rst_s_tready", 32'(s_tready), 32'd1);

    // ascending frame, full throughput
    mode = 0; sort_dir = 1'b1;
    send_beat(32'h0002_0001, 1'b0);
    send_beat(32'h0003_0003, 1'b1);
    wait_done();
    chk("t1_dup", 32'(dup_nums), 32'd1);
    chk("t1_cnt", 32'(elem_cnt), 32'd4);
    chk("t1_err", 32'(order_err), 32'd0);
    chk("t1_rate", 32'(hs_cyc[$] - hs_cyc[$-3]), 32'd3);
    realign();

    // same frame with alternating m_tready
    mode = 1;
    send_beat(32'h0002_0001, 1'b0);
    send_beat(32'h0003_0003, 1'b1);
    wait_done();
    chk("t2_dup", 32'(dup_nums), 32'd1);
    chk("t2_cnt", 32'(elem_cnt), 32'd4);
    chk("t2_err", 32'(order_err), 32'd0);
    realign();

    // descending violation
    mode = 0; sort_dir = 1'b0;
    repeat (2) realign();
    send_beat(32'h0005_0004, 1'b1);
    wait_done();
    chk("t3_dup", 32'(dup_nums), 32'd0);
    chk("t3_cnt", 32'(elem_cnt), 32'd2);
    chk("t3_err", 32'(order_err), 32'd1);
    realign();

    // back-to-back frames
    sort_dir = 1'b1;
    d0 = done_cnt;
    send_beat(32'h0007_0007, 1'b1);
    send_beat(32'h0009_0007, 1'b1);
    n = 0;
    while (done_cnt < d0 + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t4_done_pulses", 32'(done_cnt - d0), 32'd2);
    chk("t4_dup", 32'(dup_nums), 32'd0);
    chk("t4_cnt", 32'(elem_cnt), 32'd2);
    chk("t4_rate", 32'(hs_cyc[$] - hs_cyc[$-3]), 32'd3);
    realign();

    // all-equal frames, both directions
    for (int dir = 1; dir >= 0; dir--) begin
      sort_dir = 1'(dir);
      for (int b = 0; b < 4; b++) send_beat(32'hAAAA_AAAA, 1'(b == 3));
      wait_done();
      chk("t5_dup", 32'(dup_nums), 32'd7);
      chk("t5_cnt", 32'(elem_cnt), 32'd8);
      chk("t5_err", 32'(order_err), 32'd0);
      realign();
    end

    // reset while the second beat of a frame sits in its low half
    sort_dir = 1'b1;
    send_beat(32'h0002_0001, 1'b0);
    repeat (3) realign();
    mode = 3;
    m_tready = 1'b0;
    send_beat(32'h0004_0003, 1'b0);
    repeat (2) realign();
    reset = 1'b1;
    #1;
    chk("t6_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("t6_s_tready", 32'(s_tready), 32'd0);
    chk("t6_dup", 32'(dup_nums), 32'd0);
    chk("t6_cnt", 32'(elem_cnt), 32'd0);
    chk("t6_err", 32'(order_err), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    realign();
    reset = 1'b0;
    mode = 0;
    m_tready = 1'b1;
    realign();
    send_beat(32'h0006_0006, 1'b1);
    wait_done();
    chk("t6_fresh_dup", 32'(dup_nums), 32'd1);
    chk("t6_fresh_cnt", 32'(elem_cnt), 32'd2);
    chk("t6_fresh_err", 32'(order_err), 32'd0);
    realign();

    // randomized frames, random backpressure, gaps and direction
    mode = 2;
    rand_dir = 1'b1;
    for (int f = 0; f < 40; f++) begin
      nb = $urandom_range(1, 4);
      asc = 1'($urandom_range(0, 1));
      v = 16'($urandom_range(0, 7));
      for (int b = 0; b < nb; b++) begin
        lo_v = v;
        v = asc ? v + 16'($urandom_range(0, 2)) : 16'($urandom_range(0, 7));
        send_beat({v, lo_v}, 1'(b == nb - 1));
        v = asc ? v + 16'($urandom_range(0, 2)) : 16'($urandom_range(0, 7));
        repeat ($urandom_range(0, 2)) realign();
      end
    end
    n = 0;
    while ((exp_q.size() != 0 || stat_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    rand_dir = 1'b0;
    chk("drain_elements", 32'(exp_q.size()), 32'd0);
    chk("drain_stats", 32'(stat_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_sort_unpacker.md
# axi_sort_unpacker

Downstream consumer of the sorter's packed AXI-Stream output. Splits each 32-bit beat (two 16-bit elements, low half first) into a 16-bit element stream and computes per-frame statistics on the fly: adjacent-duplicate count, element count and a sticky sort-order violation flag. Sits between the sorter's `aout_*` port and the DMA/readback path. The duplicate count is the reference value for the sorter's own `dup_nums`.

## Interface
- `DATA_WIDTH`, 32, input beat width; must equal 2*`ELEM_WIDTH`
- `ELEM_WIDTH`, 16, element width
- `CNT_WIDTH`, 16, width of the duplicate and element counters
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state and outputs
- `sort_dir`  in  1  1 = ascending, 0 = descending; latched on the first element of each frame
- `s_tdata`  in  `DATA_WIDTH`  packed beat; [15:0] is emitted first, [31:16] second
- `s_tvalid`  in  1  beat valid
- `s_tready`  out  1  beat accepted when `s_tvalid && s_tready`
- `s_tlast`  in  1  last beat of frame
- `m_tdata`  out  `ELEM_WIDTH`  element
- `m_tvalid`  out  1  element valid
- `m_tready`  in  1  downstream ready
- `m_tlast`  out  1  last element of frame (high half of a `s_tlast` beat)
- `dup_nums`  out  `CNT_WIDTH`  duplicate count of the last completed frame
- `elem_cnt`  out  `CNT_WIDTH`  element count of the last completed frame
- `order_err`  out  1  last completed frame contained an order violation
- `done`  out  1  one-cycle pulse: frame statistics updated

## Operation
- One beat buffer (`buf_data`, `buf_last`) and an FSM with three states:
  - EMPTY: `s_tready`=1 and `m_tvalid`=0. An accepted beat is captured into the buffer -> LO.
  - LO: `m_tvalid`=1, `m_tdata`=`buf_data[15:0]`, `m_tlast`=0, `s_tready`=0. On an m handshake -> HI.
  - HI: `m_tvalid`=1, `m_tdata`=`buf_data[31:16]`, `m_tlast`=`buf_last`, `s_tready`=`m_tready`.
    - m handshake with an s handshake in the same cycle: capture the new beat -> LO.
    - m handshake alone -> EMPTY.
- Statistics are updated on every m handshake (element `e`, previous element `p` in the same frame):
  - First element of the frame (`first`=1): latch `sort_dir`, no comparison, element count := 1, duplicate count := 0, error := 0.
  - Otherwise, if `e == p`, increment the duplicate count.
  - Otherwise, set the error flag if (`sort_dir`=1 and `e < p`) or (`sort_dir`=0 and `e > p`). Equal elements are never an error.
  - Increment the element count. Both counters saturate at 2^`CNT_WIDTH`-1; there is no wrap-around.
- Comparisons are unsigned, `ELEM_WIDTH` wide.
- On the handshake with `m_tlast`=1:
  - The final counts (including this element) and the error flag are registered into `dup_nums`, `elem_cnt` and `order_err`.
  - `done`=1 for the following cycle.
  - `first` := 1, so the next frame never compares against the previous frame's last element.
- `dup_nums`, `elem_cnt` and `order_err` hold their values until the next `done`.
- `m_tdata` and `m_tlast` are stable while `m_tvalid && !m_tready`.

## Timing
- Reset values: `s_tready`=0 while `reset`=1 and 1 in the first cycle after release (EMPTY); `m_tvalid`=0, `m_tdata`=0, `m_tlast`=0, `dup_nums`=0, `elem_cnt`=0, `order_err`=0, `done`=0; `first`=1.
- Latency: a beat accepted at edge N gives its low element valid in cycle N+1, and its high element in cycle N+2 if `m_tready`=1.
- Throughput: one element per cycle with `m_tready` held high (a beat every 2 cycles, accepted in HI).
- `done` asserts in the cycle after the `m_tlast` handshake; the statistics outputs are valid in that same cycle.
- Reset mid-frame: the partial frame is discarded and all outputs return to their reset values immediately; nothing of the frame is emitted after reset is released.
- `s_tready` depends combinationally on `m_tready` in HI only. There are no other combinational input-to-output paths.

## Test plan
- Ascending frame, `sort_dir`=1, `m_tready`=1, beats 0x0002_0001 then 0x0003_0003 (`s_tlast`) -> m stream 1,2,3,3 on consecutive cycles, `m_tlast` on element 4; next cycle `done`=1, `dup_nums`=1, `elem_cnt`=4, `order_err`=0.
- Same frame with `m_tready` pattern 1,0,1,0,... -> identical element sequence with no loss or repeat; `s_tready`=0 in LO; `m_tdata` stable while stalled.
- Descending violation, `sort_dir`=0, single beat 0x0005_0004 with `s_tlast` -> elements 4,5; `order_err`=1, `dup_nums`=0, `elem_cnt`=2.
- Back-to-back frames: frame A is 0x0007_0007 (last), frame B is 0x0009_0007 (last), no gap -> B's first element 7 is not counted as a duplicate; after B, `dup_nums`=0; two `done` pulses; 1 element/cycle sustained.
- All-equal frame: four beats of 0xAAAA_AAAA -> `dup_nums`=7, `elem_cnt`=8, `order_err`=0 in both directions.
- Reset asserted in LO of the second beat of a frame -> `m_tvalid`=0 at once and stats stay 0; a fresh frame afterwards reports only its own counts.
